// File: rtl/param_reg.sv
// -----------------------------------------------------------------------------
// param_reg
//
// Parameterised-width D register used as a pipeline / retiming element in the
// datapath. DEPTH back-to-back W-bit register stages sit between d_in and
// d_out, so d_out lags d_in by exactly DEPTH rising edges. With the default
// parameters this is a single 8-bit flop bank.
//
// Parameters:
//   W       data width in bits (1..1024)
//   RST_VAL value loaded into every stage on reset; truncated or zero-extended
//           to W bits
//   DEPTH   number of register stages, equal to the latency in cycles (1..16)
//
// Ports:
//   clk     input   1   clock; all state updates on the rising edge
//   resetn  input   1   synchronous clear, ACTIVE-HIGH despite the name (the
//                       name is kept for consistency with the codebase)
//   d_in    input   W   data input
//   d_out   output  W   data output, driven straight from the last stage flop
//
// There is no enable and no handshake: every stage loads on every edge. Bits
// are passed through untouched (no arithmetic, no sign handling).
// -----------------------------------------------------------------------------
module param_reg #(
   parameter int              W       = 8,
   parameter logic [1023:0]   RST_VAL = 1024'd0,
   parameter int              DEPTH   = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] d_out
);

   // Out-of-range geometry is rejected while elaborating, never at run time.
   if ((W < 1) || (DEPTH < 1) || (DEPTH > 16)) begin : g_bad_param
      $error("param_reg: illegal parameters W=%0d DEPTH=%0d", W, DEPTH);
   end

   // RST_VAL is carried as a wide vector so that narrower literals are
   // zero-extended and wider ones are truncated to the bus width here.
   localparam logic [W-1:0] RST_VAL_W = RST_VAL[W-1:0];

   // stage_r[0] is nearest d_in, stage_r[DEPTH-1] drives d_out.
   logic [W-1:0] stage_r [DEPTH];

   // Stage shift register: one-edge flush of every stage on reset, otherwise
   // shift d_in in at stage 0 and move each stage one step toward d_out.
   always_ff @(posedge clk) begin
      if (resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RST_VAL_W;
         end
      end else begin
         stage_r[0] <= d_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   // Output comes straight from a flop, so it cannot glitch with d_in.
   assign d_out = stage_r[DEPTH-1];

endmodule

// File: tb/tb_param_reg.sv
// -----------------------------------------------------------------------------
// tb_param_reg
//
// Two instances share one clock:
//   u_a : W=8,  DEPTH=1, RST_VAL=0
//   u_b : W=16, DEPTH=3, RST_VAL=16'h1234
// Directed vectors for u_a come from a table, u_b and the sub-cycle reset
// glitch use short hand-written sequences, then both instances run on random
// data and random resets against a history-based reference model.
// -----------------------------------------------------------------------------
module tb_param_reg;

   localparam int          A_W     = 8;
   localparam int          A_DEPTH = 1;
   localparam logic [15:0] A_RST   = 16'h0000;
   localparam int          B_W     = 16;
   localparam int          B_DEPTH = 3;
   localparam logic [15:0] B_RST   = 16'h1234;

   logic               clk;
   logic               resetn_a;
   logic [A_W-1:0]     d_in_a;
   logic [A_W-1:0]     d_out_a;
   logic               resetn_b;
   logic [B_W-1:0]     d_in_b;
   logic [B_W-1:0]     d_out_b;

   int checks;
   int errors;

   param_reg #(.W(A_W), .RST_VAL(1024'h0), .DEPTH(A_DEPTH)) u_a (
      .clk    (clk),
      .resetn (resetn_a),
      .d_in   (d_in_a),
      .d_out  (d_out_a)
   );

   param_reg #(.W(B_W), .RST_VAL(1024'h1234), .DEPTH(B_DEPTH)) u_b (
      .clk    (clk),
      .resetn (resetn_b),
      .d_in   (d_in_b),
      .d_out  (d_out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a log of what each instance saw at every rising edge.
   bit          hr_a[$];
   logic [15:0] hd_a[$];
   bit          hr_b[$];
   logic [15:0] hd_b[$];

   always @(posedge clk) begin
      hr_a.push_back(resetn_a === 1'b1);
      hd_a.push_back({8'h00, d_in_a});
      hr_b.push_back(resetn_b === 1'b1);
      hd_b.push_back(d_in_b);
   end

   // Value expected on d_out after the most recent edge, derived from the
   // rules: any reset within the last DEPTH edges leaves RST_VAL at the
   // output, otherwise it is the d_in sampled DEPTH-1 edges ago.
   // Bit 16 of the result says whether the value is defined at all.
   function automatic logic [16:0] model(input int inst);
      int          k;
      int          depth;
      logic [15:0] rv;
      if (inst == 0) begin
         k = hr_a.size() - 1; depth = A_DEPTH; rv = A_RST;
      end else begin
         k = hr_b.size() - 1; depth = B_DEPTH; rv = B_RST;
      end
      for (int j = 0; j < depth; j++) begin
         if (k - j < 0) return {1'b0, 16'h0000};
         if (inst == 0 ? hr_a[k-j] : hr_b[k-j]) return {1'b1, rv};
      end
      return {1'b1, (inst == 0) ? hd_a[k-depth+1] : hd_b[k-depth+1]};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step_a(input logic r, input logic [7:0] d);
      resetn_a = r;
      d_in_a   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input logic r, input logic [15:0] d);
      resetn_b = r;
      d_in_b   = d;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[16];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [16:0] m;
      checks   = 0;
      errors   = 0;
      resetn_a = 1'b1;
      d_in_a   = 8'hA5;
      resetn_b = 1'b1;
      d_in_b   = 16'hFFFF;

      // Reset held for 7 edges with d_in=A5, then loads, mid-stream reset,
      // and boundary values.
      for (int i = 0; i < 7; i++) vecs[i] = '{1'b1, 8'hA5, 8'h00};
      vecs[7]  = '{1'b0, 8'h24, 8'h24};
      vecs[8]  = '{1'b0, 8'h81, 8'h81};
      vecs[9]  = '{1'b0, 8'h09, 8'h09};
      vecs[10] = '{1'b0, 8'h63, 8'h63};
      vecs[11] = '{1'b1, 8'h0D, 8'h00};
      vecs[12] = '{1'b0, 8'h0D, 8'h0D};
      vecs[13] = '{1'b0, 8'hFF, 8'hFF};
      vecs[14] = '{1'b0, 8'h00, 8'h00};
      vecs[15] = '{1'b0, 8'h80, 8'h80};

      for (int i = 0; i < 16; i++) begin
         step_a(vecs[i].rst, vecs[i].din);
         check($sformatf("a_vec%0d", i), {8'h00, d_out_a}, {8'h00, vecs[i].exp});
      end

      // Sub-cycle reset pulse that is low again before the next edge.
      step_a(1'b0, 8'h3C);
      check("a_pre_glitch", {8'h00, d_out_a}, 16'h003C);
      d_in_a = 8'h5A;
      #2 resetn_a = 1'b1;
      #2 resetn_a = 1'b0;
      @(posedge clk);
      #1;
      check("a_glitch_no_clear", {8'h00, d_out_a}, 16'h005A);
      step_a(1'b0, 8'hC3);
      check("a_after_glitch", {8'h00, d_out_a}, 16'h00C3);

      // Three-stage instance: reset value, then BEEF emerges after 3 edges.
      step_b(1'b1, 16'hFFFF);
      check("b_reset", d_out_b, 16'h1234);
      step_b(1'b0, 16'hBEEF);
      check("b_edge1", d_out_b, 16'h1234);
      step_b(1'b0, 16'h1111);
      check("b_edge2", d_out_b, 16'h1234);
      step_b(1'b0, 16'h2222);
      check("b_edge3", d_out_b, 16'hBEEF);
      step_b(1'b0, 16'h3333);
      check("b_edge4", d_out_b, 16'h1111);
      // Mid-stream flush of all three stages in one edge.
      step_b(1'b1, 16'h4444);
      check("b_flush", d_out_b, 16'h1234);
      step_b(1'b0, 16'h5555);
      check("b_refill1", d_out_b, 16'h1234);

      // Random data and occasional resets on both instances.
      for (int n = 0; n < 400; n++) begin
         resetn_a = ($urandom_range(0, 15) == 0);
         d_in_a   = 8'($urandom);
         resetn_b = ($urandom_range(0, 15) == 0);
         d_in_b   = 16'($urandom);
         @(posedge clk);
         #1;
         m = model(0);
         if (m[16]) check("a_rand", {8'h00, d_out_a}, m[15:0]);
         m = model(1);
         if (m[16]) check("b_rand", d_out_b, m[15:0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_reg.md
Name: param_reg

Overview:
- Parameterised-width D register: captures d_in on every rising clock edge and presents it on d_out one cycle later.
- Basic pipeline/retiming element in the datapath, with a synchronous clear.
- Optional parameters set the reset value and add extra pipeline stages; with defaults it is a single W-bit flop bank.

Parameters:
- W, 8, data bus width in bits; legal range 1..1024.
- RST_VAL, 0, value loaded into every stage on reset; truncated or zero-extended to W bits.
- DEPTH, 1, number of register stages between d_in and d_out; legal range 1..16; equals latency in cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous reset, active-high. resetn=1 at a rising edge clears the register. The name is kept for codebase consistency; polarity is high.
- d_in  input  W  data input.
- d_out  output  W  data output, driven directly from the last stage flop (no combinational path from d_in).

Behaviour:
- Storage:
  - DEPTH stages, stage[0..DEPTH-1], each W bits.
  - d_out = stage[DEPTH-1].
- Rising clk edge with resetn=1:
  - All stages load RST_VAL[W-1:0].
  - d_in is ignored on that edge.
  - d_out reads RST_VAL from just after that edge.
- Rising clk edge with resetn=0:
  - stage[0] <= d_in.
  - stage[i] <= stage[i-1] for i in 1..DEPTH-1.
- Latency:
  - With DEPTH=1, d_out after edge k equals d_in sampled at edge k.
  - In general, d_out after edge k equals d_in sampled at edge k-DEPTH+1.
- Reset timing:
  - Reset is synchronous only. A resetn pulse between edges has no effect unless it is high at an edge.
  - Reset asserted mid-stream flushes every stage in one edge.
  - After deassertion, the first d_in value reaches d_out DEPTH edges later.
  - Until then, d_out shows RST_VAL for stages not yet refilled.
- Power-up: d_out is undefined (X in simulation) until the first edge with resetn=1. No initial values are relied on.
- No enable, no handshake; the register loads every cycle.
- Width: no arithmetic. Bits pass through unchanged, MSB stays MSB, no sign handling.
- Outputs change only on rising clk edges; d_out is glitch-free with respect to d_in changes between edges.
- Parameter checking: elaboration fails (generate-time error) if W<1, DEPTH<1 or DEPTH>16.

Test Plan:
- Reset: W=8, DEPTH=1, RST_VAL=0. Drive d_in=8'hA5, hold resetn=1 for 7 edges -> d_out=8'h00 after the first edge and stays 8'h00.
- Basic load: resetn=0. Apply d_in 8'h24, 8'h81, 8'h09, 8'h63 on successive edges -> d_out equals each value one edge later, i.e. 8'h24 after edge 1, 8'h81 after edge 2, and so on.
- Reset mid-stream: d_out=8'h63 and d_in=8'h0D, assert resetn=1 for one edge -> d_out=8'h00. Deassert -> next edge d_out=d_in.
- Boundary values: d_in=8'hFF then 8'h00 then 8'h80 -> d_out reproduces each exactly one edge later; no bit loss at MSB or LSB.
- Parameter variant: W=16, DEPTH=3, RST_VAL=16'h1234.
  - After reset, d_out=16'h1234.
  - Drive 16'hBEEF at edge 1 -> d_out=16'h1234 after edges 1 and 2, then 16'hBEEF after edge 3.
- Sub-cycle reset glitch: resetn pulsed high and low between two edges, never high at a rising edge -> no clear; d_out keeps tracking d_in.
